mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the IF fetch path and the MEM-stage load/store path.
- Arbitrates the two requests and sequences each access through a req/ready backend handshake.
- Generates per-requester stall signals for the hazard logic.
- Bounds IF starvation and backend hangs with counters.

Parameters:
- MAX_DATA_STREAK, 4: maximum consecutive data grants made while IF is also requesting; the next contested grant goes to IF.
- TIMEOUT_CYCLES, 255: maximum cycles in ACCESS waiting for m_ready_i before the access is aborted with an error.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-high (1 = reset, despite the name).
- if_req_i  in  1  fetch request; held until if_valid_o.
- if_addr_i  in  32  fetch address.
- if_rdata_o  out  32  fetched instruction; valid with if_valid_o.
- if_valid_o  out  1  one-cycle fetch completion pulse.
- d_req_i  in  1  load/store request; held until d_valid_o.
- d_we_i  in  1  1 = store, 0 = load.
- d_addr_i  in  32  data address.
- d_wdata_i  in  32  store data.
- d_funct3_i  in  3  access size/sign, passed through to the backend.
- d_rdata_o  out  32  load data; 0 for stores.
- d_valid_o  out  1  one-cycle data completion pulse.
- m_req_o  out  1  backend request.
- m_we_o  out  1  backend write enable.
- m_addr_o  out  32  backend address.
- m_wdata_o  out  32  backend write data.
- m_funct3_o  out  3  backend size/sign.
- m_ready_i  in  1  backend completion; m_rdata_i is valid in the same cycle.
- m_rdata_i  in  32  backend read data.
- if_stall_o  out  1  = if_req_i & ~if_valid_o.
- d_stall_o  out  1  = d_req_i & ~d_valid_o.
- err_o  out  1  timeout flag; pulses together with the aborted requester's valid.
- busy_o  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset forces IDLE.
- Reset values: every output 0; streak counter 0; timeout counter 0; owner register = IF.
- IDLE, no request: stay in IDLE.
- IDLE, grant: register owner, we, addr, wdata and funct3 into the m_* registers; go to ACCESS.
  - Fetch grants force m_we_o = 0 and m_funct3_o = 3'b010.
- Arbitration priority:
  - Data wins, unless both are requesting and streak == MAX_DATA_STREAK; then IF wins.
  - Contested data grant: streak increments (saturating).
  - Any IF grant: streak clears.
  - Uncontested data grant: streak clears.
- ACCESS: m_req_o = 1, and all m_* fields stay stable until m_ready_i.
  - On m_ready_i: capture m_rdata_i into the owner's rdata register (0 for a store); go to RESP.
  - If m_ready_i is still low when the timeout counter reaches TIMEOUT_CYCLES-1: drop m_req_o, set rdata to 0, latch the error, go to RESP.
  - The timeout counter clears on entering ACCESS.
- RESP: the owner's valid pulses for exactly 1 cycle; err_o pulses in the same cycle if latched; m_req_o = 0. Next state is always IDLE.
- Latency:
  - Request sampled in IDLE at cycle t; m_req_o high at t+1.
  - With m_ready_i at t+1, valid is seen at t+2.
  - Minimum 3 cycles per access; there is no back-to-back pipelining.
- Requests arriving during ACCESS or RESP wait, and are sampled in the next IDLE.
- A requester dropping its req early is illegal; the access completes regardless.
- rdata outputs hold their last value between pulses; consumers use them only with valid.
- Reset during ACCESS: m_req_o goes low the next cycle, no valid or err_o is issued, and a late m_ready_i is ignored.
- m_ready_i outside ACCESS: ignored.

Test Plan:
1. IF only: if_req_i = 1, if_addr_i = 0x100, backend ready 1 cycle later with 0x00500093 → m_addr_o = 0x100, m_we_o = 0, if_valid_o at t+2 with if_rdata_o = 0x00500093, if_stall_o high at t and t+1.
2. Store: d_req_i = 1, d_we_i = 1, d_addr_i = 0x2000, d_wdata_i = 0xDEADBEEF, d_funct3_i = 3'b010 → m_we_o = 1, m_wdata_o = 0xDEADBEEF, d_valid_o pulses once, d_rdata_o = 0.
3. Contention: both requests held continuously, MAX_DATA_STREAK = 4 → grant order D, D, D, D, I, D…; IF completes exactly once per 5 grants.
4. Timeout: TIMEOUT_CYCLES = 8, m_ready_i never asserted → m_req_o falls after 8 ACCESS cycles; d_valid_o and err_o pulse together; d_rdata_o = 0; FSM returns to IDLE.
5. Reset mid-access: rst_n = 1 in the 2nd ACCESS cycle, then m_ready_i = 1 → no valid pulse; all outputs 0; streak counter 0; a new IF request afterwards completes normally.
6. Slow backend: m_ready_i asserted 5 cycles after m_req_o while m_addr_o/m_wdata_o are checked every cycle → fields stay stable throughout; valid arrives 1 cycle after m_ready_i.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and load/store paths onto one single-ported memory.
// Each access runs IDLE -> ACCESS -> RESP with starvation and timeout guards.
module mem_port_arbiter #(
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_valid_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [2:0]  d_funct3_i,
    output logic [31:0] d_rdata_o,
    output logic        d_valid_o,
    output logic        m_req_o,
    output logic        m_we_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_wdata_o,
    output logic [2:0]  m_funct3_o,
    input  logic        m_ready_i,
    input  logic [31:0] m_rdata_i,
    output logic        if_stall_o,
    output logic        d_stall_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state;
    state_t state_nx;

    logic          owner_d;
    logic          err_q;
    logic [SW-1:0] streak;
    logic [TW-1:0] tcnt;
    logic          contested;
    logic          grant_d;
    logic          grant_i;
    logic          timeout_hit;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        contested   = if_req_i & d_req_i;
        // Data normally wins; IF gets the slot once the streak is exhausted.
        grant_d     = d_req_i & ~(contested && streak == SW'(MAX_DATA_STREAK));
        grant_i     = if_req_i & ~grant_d;
        timeout_hit = ~m_ready_i && tcnt == TW'(TIMEOUT_CYCLES - 1);
        state_nx    = state;
        case (state)
            IDLE: begin
                if (grant_d || grant_i) begin
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                if (m_ready_i || timeout_hit) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        m_req_o    = state == ACCESS;
        busy_o     = state != IDLE;
        if_valid_o = state == RESP && !owner_d;
        d_valid_o  = state == RESP && owner_d;
        err_o      = state == RESP && err_q;
        if_stall_o = if_req_i & ~if_valid_o;
        d_stall_o  = d_req_i & ~d_valid_o;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            owner_d    <= 1'b0;
            err_q      <= 1'b0;
            streak     <= '0;
            tcnt       <= '0;
            m_we_o     <= 1'b0;
            m_addr_o   <= '0;
            m_wdata_o  <= '0;
            m_funct3_o <= '0;
            if_rdata_o <= '0;
            d_rdata_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        owner_d    <= 1'b1;
                        m_we_o     <= d_we_i;
                        m_addr_o   <= d_addr_i;
                        m_wdata_o  <= d_wdata_i;
                        m_funct3_o <= d_funct3_i;
                        tcnt       <= '0;
                        err_q      <= 1'b0;
                        if (!contested) begin
                            streak <= '0;
                        end else if (streak != SW'(MAX_DATA_STREAK)) begin
                            streak <= streak + SW'(1);
                        end
                    end else if (grant_i) begin
                        owner_d    <= 1'b0;
                        m_we_o     <= 1'b0;
                        m_addr_o   <= if_addr_i;
                        m_wdata_o  <= '0;
                        m_funct3_o <= 3'b010;
                        tcnt       <= '0;
                        err_q      <= 1'b0;
                        streak     <= '0;
                    end
                end
                ACCESS: begin
                    if (m_ready_i) begin
                        if (owner_d) begin
                            d_rdata_o <= m_we_o ? '0 : m_rdata_i;
                        end else begin
                            if_rdata_o <= m_rdata_i;
                        end
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                        if (owner_d) begin
                            d_rdata_o <= '0;
                        end else begin
                            if_rdata_o <= '0;
                        end
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store, contention,
// timeout, reset mid-access and slow backend scenarios.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_valid_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [2:0]  d_funct3_i;
    logic [31:0] d_rdata_o;
    logic        d_valid_o;
    logic        m_req_o;
    logic        m_we_o;
    logic [31:0] m_addr_o;
    logic [31:0] m_wdata_o;
    logic [2:0]  m_funct3_o;
    logic        m_ready_i;
    logic [31:0] m_rdata_i;
    logic        if_stall_o;
    logic        d_stall_o;
    logic        err_o;
    logic        busy_o;

    int n_chk  = 0;
    int n_fail = 0;

    mem_port_arbiter #(
        .MAX_DATA_STREAK(4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req_i  (if_req_i),
        .if_addr_i (if_addr_i),
        .if_rdata_o(if_rdata_o),
        .if_valid_o(if_valid_o),
        .d_req_i   (d_req_i),
        .d_we_i    (d_we_i),
        .d_addr_i  (d_addr_i),
        .d_wdata_i (d_wdata_i),
        .d_funct3_i(d_funct3_i),
        .d_rdata_o (d_rdata_o),
        .d_valid_o (d_valid_o),
        .m_req_o   (m_req_o),
        .m_we_o    (m_we_o),
        .m_addr_o  (m_addr_o),
        .m_wdata_o (m_wdata_o),
        .m_funct3_o(m_funct3_o),
        .m_ready_i (m_ready_i),
        .m_rdata_i (m_rdata_i),
        .if_stall_o(if_stall_o),
        .d_stall_o (d_stall_o),
        .err_o     (err_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        if_req_i = 0; if_addr_i = 0;
        d_req_i = 0; d_we_i = 0; d_addr_i = 0;
        d_wdata_i = 0; d_funct3_i = 0;
        m_ready_i = 0; m_rdata_i = 0;
        tick(); tick();
        chk("rst_m_req", {31'b0, m_req_o}, 0);
        chk("rst_busy", {31'b0, busy_o}, 0);
        chk("rst_m_addr", m_addr_o, 0);
        chk("rst_if_rdata", if_rdata_o, 0);
        chk("rst_d_rdata", d_rdata_o, 0);
        chk("rst_valids", {30'b0, if_valid_o, d_valid_o}, 0);
        chk("rst_err", {31'b0, err_o}, 0);
        rst_n = 1'b0;
        tick();
    endtask

    task automatic test_if_only();
        if_req_i = 1; if_addr_i = 32'h100;
        #1;
        chk("if_stall_t", {31'b0, if_stall_o}, 1);
        tick();
        chk("if_m_req", {31'b0, m_req_o}, 1);
        chk("if_m_addr", m_addr_o, 32'h100);
        chk("if_m_we", {31'b0, m_we_o}, 0);
        chk("if_m_funct3", {29'b0, m_funct3_o}, 32'h2);
        chk("if_stall_t1", {31'b0, if_stall_o}, 1);
        m_ready_i = 1; m_rdata_i = 32'h00500093;
        tick();
        chk("if_valid", {31'b0, if_valid_o}, 1);
        chk("if_rdata", if_rdata_o, 32'h00500093);
        chk("if_stall_resp", {31'b0, if_stall_o}, 0);
        chk("if_m_req_resp", {31'b0, m_req_o}, 0);
        if_req_i = 0; m_ready_i = 0;
        tick();
        chk("if_valid_drop", {31'b0, if_valid_o}, 0);
        chk("if_busy_idle", {31'b0, busy_o}, 0);
    endtask

    task automatic test_store();
        int pulses = 0;
        d_req_i = 1; d_we_i = 1; d_addr_i = 32'h2000;
        d_wdata_i = 32'hDEADBEEF; d_funct3_i = 3'b010;
        tick();
        chk("st_m_we", {31'b0, m_we_o}, 1);
        chk("st_m_wdata", m_wdata_o, 32'hDEADBEEF);
        chk("st_m_addr", m_addr_o, 32'h2000);
        m_ready_i = 1; m_rdata_i = 32'h12345678;
        tick();
        d_req_i = 0; m_ready_i = 0;
        for (int i = 0; i < 4; i++) begin
            if (d_valid_o) pulses++;
            if (i == 0) chk("st_d_rdata", d_rdata_o, 0);
            tick();
        end
        chk("st_pulses", pulses, 1);
    endtask

    task automatic test_contention();
        logic exp_if;
        int n;
        if_req_i = 1; if_addr_i = 32'h400;
        d_req_i = 1; d_we_i = 0; d_addr_i = 32'h800;
        m_ready_i = 1; m_rdata_i = 32'h11112222;
        for (int g = 0; g < 10; g++) begin
            exp_if = (g % 5) == 4;
            n = 0;
            tick();
            while (!m_req_o && n < 6) begin
                tick();
                n++;
            end
            chk("ct_grant_addr", m_addr_o, exp_if ? 32'h400 : 32'h800);
            tick();
            chk("ct_valid", {30'b0, if_valid_o, d_valid_o},
                exp_if ? 32'h2 : 32'h1);
        end
        if_req_i = 0; d_req_i = 0; m_ready_i = 0;
        tick();
        chk("ct_d_rdata", d_rdata_o, 32'h11112222);
    endtask

    task automatic test_timeout();
        d_req_i = 1; d_we_i = 0; d_addr_i = 32'h3000;
        m_ready_i = 0;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("to_m_req", {31'b0, m_req_o}, 1);
            tick();
        end
        chk("to_m_req_fall", {31'b0, m_req_o}, 0);
        chk("to_valid_err", {30'b0, d_valid_o, err_o}, 32'h3);
        chk("to_d_rdata", d_rdata_o, 0);
        d_req_i = 0;
        tick();
        chk("to_idle", {30'b0, busy_o, err_o}, 0);
    endtask

    task automatic test_reset_mid();
        d_req_i = 1; d_we_i = 0; d_addr_i = 32'h3004;
        m_ready_i = 0;
        tick();
        tick();
        chk("rm_in_access", {31'b0, m_req_o}, 1);
        rst_n = 1; d_req_i = 0;
        tick();
        rst_n = 0; m_ready_i = 1; m_rdata_i = 32'hBAD0BAD0;
        #1;
        chk("rm_m_req", {31'b0, m_req_o}, 0);
        chk("rm_m_addr", m_addr_o, 0);
        chk("rm_outs", {27'b0, if_valid_o, d_valid_o, err_o, busy_o,
                        m_we_o}, 0);
        tick();
        chk("rm_late_ready", {29'b0, if_valid_o, d_valid_o, busy_o}, 0);
        chk("rm_d_rdata", d_rdata_o, 0);
        m_ready_i = 0;
        if_req_i = 1; if_addr_i = 32'h104;
        tick();
        chk("rm_new_addr", m_addr_o, 32'h104);
        m_ready_i = 1; m_rdata_i = 32'h00A00113;
        tick();
        chk("rm_new_valid", {31'b0, if_valid_o}, 1);
        chk("rm_new_rdata", if_rdata_o, 32'h00A00113);
        if_req_i = 0; m_ready_i = 0;
        tick();
    endtask

    task automatic test_slow_backend();
        d_req_i = 1; d_we_i = 1; d_addr_i = 32'h44;
        d_wdata_i = 32'hCAFEF00D; d_funct3_i = 3'b001;
        tick();
        for (int i = 0; i < 6; i++) begin
            if (i == 5) m_ready_i = 1;
            chk("sb_addr", m_addr_o, 32'h44);
            chk("sb_wdata", m_wdata_o, 32'hCAFEF00D);
            chk("sb_req", {31'b0, m_req_o}, 1);
            chk("sb_no_valid", {31'b0, d_valid_o}, 0);
            if (i == 2) begin
                d_addr_i = 32'h99;
                d_wdata_i = 32'h0;
            end
            tick();
        end
        chk("sb_valid", {31'b0, d_valid_o}, 1);
        chk("sb_err", {31'b0, err_o}, 0);
        d_req_i = 0; m_ready_i = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_if_only();
        test_store();
        test_contention();
        test_timeout();
        test_reset_mid();
        test_slow_backend();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
